// File: rtl/serial_word_loader_pkg.sv
// Shared types and sizing helpers for the serial word loader and its holding stage.
// The handshake enum is observational only; datapath state lives in bit_cnt and word_valid.
package serial_word_loader_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } hs_state_e;

  function automatic int cnt_w(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

  function automatic hs_state_e hs_state(input logic valid, input logic collecting);
    if (valid) begin
      return FULL;
    end
    return collecting ? COLLECT : IDLE;
  endfunction

endpackage

// File: rtl/serial_word_loader_output_hold_reg.sv
// Word holding register with a valid flag: load wins over drain, so a load on a
// draining edge replaces the word with no bubble; otherwise the word is held until drained.
module serial_word_loader_output_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/serial_word_loader.sv
// Serial-to-parallel front end: gathers WIDTH bits into a word and hands it off on
// a valid/ready interface, stalling the serial source only on the final bit when blocked.
module serial_word_loader
  import serial_word_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sin,
  input  logic                      sin_valid,
  output logic                      sin_ready,
  input  logic                      abort,
  output logic [WIDTH-1:0]          word,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt
);

  localparam int               CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] merged;
  logic [CNT_W-1:0] wr_pos;
  logic             last_bit;
  logic             accept;
  logic             load;
  logic             hold_valid;
  hs_state_e        state_obs;

  assign last_bit  = (bit_cnt_q == LAST);
  assign sin_ready = !(last_bit && hold_valid && !word_ready);
  assign accept    = sin_valid && sin_ready && !abort;
  assign load      = accept && last_bit;
  assign wr_pos    = (MSB_FIRST != 0) ? (LAST - bit_cnt_q) : bit_cnt_q;

  // sin is only selected on an accepted bit, so an X while idle never reaches the word
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_merge
      assign merged[gi] = (accept && (wr_pos == CNT_W'(gi))) ? sin : shift_q[gi];
    end
  endgenerate

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (abort) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (accept) begin
      if (last_bit) begin
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        shift_d   = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  serial_word_loader_output_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (merged),
    .ready_i (word_ready),
    .data_o  (word),
    .valid_o (hold_valid)
  );

  assign word_valid = hold_valid;
  assign bit_cnt    = bit_cnt_q;

  assign state_obs = hs_state(hold_valid, bit_cnt_q != '0);

  // A blocked word must survive to the next edge unless reset intervenes
  a_hold_stable: assert property (@(posedge clk)
    (state_obs == FULL && !word_ready && !rst) |=> (rst || (word_valid && $stable(word))));

  a_cnt_range: assert property (@(posedge clk) bit_cnt_q <= LAST);

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench: two loaders (LSB-first and MSB-first) share one stimulus stream and are
// compared against a bit-list reference model; a separate monitor checks each presented word.
module tb_serial_word_loader;

  localparam int W = 8;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst, sin, sin_valid, abort, word_ready;
  logic sin_ready_l, sin_ready_m, word_valid_l, word_valid_m;
  logic [W-1:0] word_l, word_m;
  logic [CW-1:0] bit_cnt_l, bit_cnt_m;

  int checks = 0;
  int fails  = 0;
  bit started = 1'b0;

  // reference model state
  bit          bits[$];
  bit          occ = 1'b0;
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_m[$];

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready_l),
    .abort(abort), .word(word_l), .word_valid(word_valid_l), .word_ready(word_ready),
    .bit_cnt(bit_cnt_l)
  );

  serial_word_loader #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(sin_ready_m),
    .abort(abort), .word(word_m), .word_valid(word_valid_m), .word_ready(word_ready),
    .bit_cnt(bit_cnt_m)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus; checks pre-edge outputs against the model, then advances the model.
  task automatic step(input bit v, input bit b, input bit r, input bit a, input bit rs);
    bit exp_ready, drain, loaded;
    logic [W-1:0] wl, wm;
    @(negedge clk);
    sin_valid = v;
    sin = v ? b : 1'bx;
    word_ready = r;
    abort = a;
    rst = rs;
    started = 1'b1;
    #1;
    exp_ready = !(bits.size() == W - 1 && occ && !r);
    chk("sin_ready_lsb", int'(sin_ready_l), int'(exp_ready));
    chk("sin_ready_msb", int'(sin_ready_m), int'(exp_ready));
    chk("bit_cnt_lsb", int'(bit_cnt_l), bits.size());
    chk("bit_cnt_msb", int'(bit_cnt_m), bits.size());
    chk("word_valid_lsb", int'(word_valid_l), int'(occ));
    chk("word_valid_msb", int'(word_valid_m), int'(occ));
    $display("cyc t=%0t v=%0b b=%0b r=%0b a=%0b rst=%0b nbits=%0d occ=%0b", $time, v, b, r, a, rs, bits.size(), occ);
    if (rs) begin
      bits.delete();
      occ = 1'b0;
      q_l.delete();
      q_m.delete();
    end else begin
      drain = occ && r;
      loaded = 1'b0;
      if (a) begin
        bits.delete();
      end else if (v && exp_ready) begin
        bits.push_back(b);
        if (bits.size() == W) begin
          wl = '0;
          wm = '0;
          for (int i = 0; i < W; i++) begin
            wl = wl | (W'(bits[i]) << i);
            wm = wm | (W'(bits[i]) << (W - 1 - i));
          end
          q_l.push_back(wl);
          q_m.push_back(wm);
          bits.delete();
          loaded = 1'b1;
        end
      end
      occ = loaded ? 1'b1 : (drain ? 1'b0 : occ);
    end
  endtask

  task automatic send_byte(input logic [W-1:0] val, input bit r);
    for (int i = 0; i < W; i++) step(1'b1, val[i], r, 1'b0, 1'b0);
  endtask

  // Monitor: whenever a word is presented it must match the oldest expected word
  always begin
    @(negedge clk);
    #2;
    if (started && !rst) begin
      if (word_valid_l) begin
        if (q_l.size() == 0) chk("word_lsb_unexpected", int'(word_l), -1);
        else begin
          chk("word_lsb", int'(word_l), int'(q_l[0]));
          $display("mon lsb word=%02h exp=%02h ready=%0b", word_l, q_l[0], word_ready);
          if (word_ready) void'(q_l.pop_front());
        end
      end
      if (word_valid_m) begin
        if (q_m.size() == 0) chk("word_msb_unexpected", int'(word_m), -1);
        else begin
          chk("word_msb", int'(word_m), int'(q_m[0]));
          $display("mon msb word=%02h exp=%02h ready=%0b", word_m, q_m[0], word_ready);
          if (word_ready) void'(q_m.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sin = 1'b1; sin_valid = 1'b1; abort = 1'b0; word_ready = 1'b0;
    // reset with a live serial source
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_word_lsb", int'(word_l), 0);
    chk("reset_word_msb", int'(word_m), 0);

    // LSB-first 1,0,1,1,0,0,1,0 -> 0x4D
    send_byte(8'h4D, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("xnor_even_parity", int'(~^word_l), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // back-pressure: 0xFF held, 0x01 final bit stalls until ready rises
    send_byte(8'hFF, 1'b0);
    for (int i = 0; i < W - 1; i++) step(1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_sin_ready", int'(sin_ready_l), 0);
    chk("stall_word_held", int'(word_l), 8'hFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // back-to-back words
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // abort with a held word: partial word dropped, held word survives
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("abort_word_held", int'(word_l), 8'h5A);
    send_byte(8'h81, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // bit order 1,0,...,0: 0x01 LSB-first, 0x80 MSB-first; then reset mid-word
    send_byte(8'h01, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midword_reset_word", int'(word_m), 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0,
           ($urandom % 25) == 0, ($urandom % 150) == 0);
    end
    for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Upstream stage of the 8-input reduction-XNOR gate under fault simulation.
- Assembles a serial bit stream into WIDTH-bit parallel words.
- Presents each word on a valid/ready interface; the reducer consumes `word` as its input vector.
- Back-pressures the serial source when a completed word cannot be handed off.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32; matches the reducer input width.
- MSB_FIRST, 0, 0 = first received bit lands in word[0]; 1 = first received bit lands in word[WIDTH-1].

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_ready  output  1  loader accepts sin this cycle; a bit transfers when sin_valid && sin_ready.
- abort  input  1  synchronous clear of the partially assembled word.
- word  output  WIDTH  assembled parallel word; held stable while word_valid && !word_ready.
- word_valid  output  1  word holds a complete, unconsumed word.
- word_ready  input  1  downstream accepts word this cycle.
- bit_cnt  output  clog2(WIDTH)  number of bits collected toward the current word (0..WIDTH-1).

Behaviour:
- Reset (rst=1 at an edge): shift register = 0, bit_cnt = 0, word = 0, word_valid = 0. rst overrides every other input, including a mid-word or mid-handshake state. sin_ready is combinational and evaluates to 1 once reset is released.
- Accept: a bit is accepted on an edge where sin_valid && sin_ready.
  - MSB_FIRST=0: the bit is written to position bit_cnt.
  - MSB_FIRST=1: the bit is written to position WIDTH-1-bit_cnt.
- Non-final bit (bit_cnt < WIDTH-1): the bit goes into the internal shift register; bit_cnt increments.
- Final bit (bit_cnt == WIDTH-1):
  - word <= shift register contents merged with the final bit.
  - word_valid <= 1, bit_cnt <= 0, shift register cleared.
  - Latency: word_valid rises on the edge that accepts the final bit. It is visible the following cycle.
- sin_ready = !(bit_cnt == WIDTH-1 && word_valid && !word_ready).
  - The source stalls only on the final bit, and only while the output register is occupied and not being drained.
  - Non-final bits are always accepted.
- Drain: on an edge with word_valid && word_ready, word_valid <= 0, unless a final bit is accepted on the same edge.
- Simultaneous drain and load: word is replaced by the new word and word_valid stays 1. This gives back-to-back words with no bubble.
- While word_valid && !word_ready: word and word_valid are held. The protocol forbids dropping a word.
- abort=1 at an edge:
  - bit_cnt <= 0 and the shift register is cleared.
  - Any sin bit presented that cycle is discarded; sin_ready is still driven, but abort wins.
  - word and word_valid are not affected, so a completed word survives an abort.
  - abort together with a drain: the drain proceeds normally.
- sin_valid=0: no state change other than a drain.
- bit_cnt wraps WIDTH-1 -> 0 only via a final-bit accept or abort. No other wrap exists.
- Values on sin are ignored when sin_valid=0. X on sin while sin_valid=0 must not propagate into word.

Decomposition:
- Shared package:
  - CNT_W = clog2(WIDTH) helper function.
  - Handshake enum {IDLE, COLLECT, FULL} for coverage and assertion use only. The RTL derives state from bit_cnt and word_valid.
- Sub-module output_hold_reg: the WIDTH-bit word register plus the valid flag with load/drain logic. It is reusable as the holding stage ahead of other gate-under-test blocks.
- The shift register and bit counter live in the top.

Test Plan:
- Reset: rst for 2 cycles with sin_valid=1, sin=1 -> word=8'h00, word_valid=0, bit_cnt=0, sin_ready=1 after release.
- LSB-first load: MSB_FIRST=0, stream bits 1,0,1,1,0,0,1,0 with word_ready=1 -> word=8'h4D with word_valid high for exactly 1 cycle, 1 cycle after the 8th bit; the downstream XNOR output = 1 (even parity).
- Back-pressure: word_ready=0 after the first word 8'hFF, then stream 8 more bits of 8'h01 -> sin_ready=0 while the 8th bit is presented; word holds 8'hFF; raise word_ready -> 8th bit accepted that edge and word=8'h01 the next cycle with word_valid still 1.
- Back-to-back: continuous 16 bits (8'hA5, then 8'h3C) with word_ready=1 -> two consecutive word_valid pulses 8 cycles apart, no stall cycles.
- Abort: 5 bits in (bit_cnt=5), assert abort with sin_valid=1 -> bit_cnt=0, that bit discarded; the next 8 bits of 8'h81 yield word=8'h81; a previously held word is unchanged by the abort.
- MSB_FIRST=1: stream 1,0,0,0,0,0,0,0 -> word=8'h80; reset asserted at bit_cnt=6 -> all outputs return to reset values on the next edge.
